// File: rtl/codec_ctrl_pkg.sv
// Shared types and widths for the network-coding codec job controller.
package codec_ctrl_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned COEF_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } ctrlStateT;

endpackage

// File: rtl/codec_job_ctrl_if.sv
// Job, stream A/B, codec and result signals of one codec job controller.
interface codec_job_ctrl_if #(
  parameter int unsigned LEN_W = 12
);
  import codec_ctrl_pkg::*;

  logic              iJobValid;
  logic              oJobReady;
  logic [COEF_W-1:0] iJobCoef1;
  logic [COEF_W-1:0] iJobCoef2;
  logic [LEN_W-1:0]  iJobLen;

  logic              iAValid;
  logic              oAReady;
  logic [DATA_W-1:0] iAData;
  logic              iBValid;
  logic              oBReady;
  logic [DATA_W-1:0] iBData;

  logic [COEF_W-1:0] oCoef1;
  logic [COEF_W-1:0] oCoef2;
  logic [DATA_W-1:0] oCodecIn1;
  logic [DATA_W-1:0] oCodecIn2;
  logic [DATA_W-1:0] iCodecOut;

  logic              oOutValid;
  logic              iOutReady;
  logic [DATA_W-1:0] oOutData;
  logic              oOutLast;
  logic              oJobDone;
  logic              oBusy;

  // Controller side.
  modport slave (
    input  iJobValid, iJobCoef1, iJobCoef2, iJobLen,
    input  iAValid, iAData, iBValid, iBData, iCodecOut, iOutReady,
    output oJobReady, oAReady, oBReady, oCoef1, oCoef2, oCodecIn1, oCodecIn2,
    output oOutValid, oOutData, oOutLast, oJobDone, oBusy
  );

  // Environment side: job source, packet buffers, codec and egress.
  modport master (
    output iJobValid, iJobCoef1, iJobCoef2, iJobLen,
    output iAValid, iAData, iBValid, iBData, iCodecOut, iOutReady,
    input  oJobReady, oAReady, oBReady, oCoef1, oCoef2, oCodecIn1, oCodecIn2,
    input  oOutValid, oOutData, oOutLast, oJobDone, oBusy
  );

endinterface

// File: rtl/codec_out_fifo.sv
// Synchronous result FIFO of {last, data} entries; head entry is read straight from flops.
module codec_out_fifo
  import codec_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = DATA_W + 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iWrEn,
  input  logic [WIDTH-1:0] iWrData,
  input  logic             iRdEn,
  output logic             oValid,
  output logic [WIDTH-1:0] oRdData
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [CntW-1:0]  cntQ;

  function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Writes never hit a full FIFO: the controller only issues against free credits.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) memQ[i] <= '0;
    end else begin
      if (iWrEn) begin
        memQ[wrPtrQ] <= iWrData;
        wrPtrQ       <= ptrInc(wrPtrQ);
      end
      if (iRdEn) rdPtrQ <= ptrInc(rdPtrQ);
      if (iWrEn && !iRdEn) cntQ <= cntQ + CntW'(1);
      else if (iRdEn && !iWrEn) cntQ <= cntQ - CntW'(1);
    end
  end

  assign oValid  = (cntQ != '0);
  assign oRdData = memQ[rdPtrQ];

endmodule

// File: rtl/codec_job_ctrl.sv
// Job sequencer for one GF(2^8) network-coding codec: pairs A/B beats, holds coefficients,
// tags results and buffers them in a credit-protected output FIFO.
module codec_job_ctrl
  import codec_ctrl_pkg::*;
#(
  parameter int unsigned CODEC_LAT = 2,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned LEN_W     = 12
) (
  input logic             iCLK,
  input logic             iRST,
  codec_job_ctrl_if.slave bus
);

  localparam int unsigned CredW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned PipeW = CODEC_LAT + 1;

  ctrlStateT         stateQ;
  logic [LEN_W-1:0]  remQ;
  logic [CredW-1:0]  creditsQ;
  logic [PipeW-1:0]  vldQ, lastQ;
  logic [COEF_W-1:0] coef1Q, coef2Q;
  logic [DATA_W-1:0] in1Q, in2Q;
  logic              jobDoneQ;

  logic              accept, issue, issueLast, pop;
  logic              fifoValid;
  logic [DATA_W:0]   fifoData;

  assign bus.oJobReady = (stateQ == StIdle) & ~iRST;
  assign accept        = bus.iJobValid & bus.oJobReady;
  // Gating on remQ keeps the countdown from wrapping.
  assign issue     = (stateQ == StRun) & bus.iAValid & bus.iBValid & (creditsQ != '0) &
                     (remQ != '0) & ~iRST;
  assign issueLast = issue & (remQ == LEN_W'(1));
  assign pop       = fifoValid & bus.iOutReady;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ   <= StIdle;
      remQ     <= '0;
      creditsQ <= CredW'(OUT_DEPTH);
      vldQ     <= '0;
      lastQ    <= '0;
      coef1Q   <= '0;
      coef2Q   <= '0;
      in1Q     <= '0;
      in2Q     <= '0;
      jobDoneQ <= 1'b0;
    end else begin
      jobDoneQ <= (pop & fifoData[DATA_W]) | (accept & (bus.iJobLen == '0));
      // Stage k carries the beat whose codec inputs were presented k cycles ago.
      vldQ     <= (vldQ << 1) | PipeW'(issue);
      lastQ    <= (lastQ << 1) | PipeW'(issueLast);

      if (issue && !pop) creditsQ <= creditsQ - CredW'(1);
      else if (pop && !issue) creditsQ <= creditsQ + CredW'(1);

      if (issue) begin
        in1Q <= bus.iAData;
        in2Q <= bus.iBData;
        remQ <= remQ - LEN_W'(1);
      end

      case (stateQ)
        StIdle: begin
          if (accept) begin
            coef1Q <= bus.iJobCoef1;
            coef2Q <= bus.iJobCoef2;
            remQ   <= bus.iJobLen;
            if (bus.iJobLen != '0) stateQ <= StRun;
          end
        end
        StRun:   if (issueLast) stateQ <= StDrain;
        StDrain: if (vldQ == '0) stateQ <= StIdle;
        default: stateQ <= StIdle;
      endcase
    end
  end

  codec_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DATA_W + 1)
  ) uOutFifo (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iWrEn   (vldQ[CODEC_LAT]),
    .iWrData ({lastQ[CODEC_LAT], bus.iCodecOut}),
    .iRdEn   (pop),
    .oValid  (fifoValid),
    .oRdData (fifoData)
  );

  assign bus.oAReady   = issue;
  assign bus.oBReady   = issue;
  assign bus.oCoef1    = coef1Q;
  assign bus.oCoef2    = coef2Q;
  assign bus.oCodecIn1 = in1Q;
  assign bus.oCodecIn2 = in2Q;
  assign bus.oOutValid = fifoValid;
  assign bus.oOutData  = fifoValid ? fifoData[DATA_W-1:0] : '0;
  assign bus.oOutLast  = fifoValid & fifoData[DATA_W];
  assign bus.oJobDone  = jobDoneQ;
  assign bus.oBusy     = (stateQ != StIdle);

endmodule

// File: tb/tb_codec_job_ctrl.sv
// Directed bench for codec_job_ctrl with a GF(2^8) codec model and an output scoreboard.
module tb_codec_job_ctrl;
  import codec_ctrl_pkg::*;

  localparam int unsigned CODEC_LAT = 2;
  localparam int unsigned OUT_DEPTH = 8;
  localparam int unsigned LEN_W     = 12;

  typedef struct {
    logic [7:0] c1;
    logic [7:0] c2;
    int         len;
    bit         sparse;
    int         stall;
    bit         chkLat;
    int         expStallIssued;
    logic [7:0] expByte0;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  codec_job_ctrl_if #(.LEN_W(LEN_W)) bus ();

  codec_job_ctrl #(
    .CODEC_LAT (CODEC_LAT),
    .OUT_DEPTH (OUT_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] gfVec(input logic [7:0] c, input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = gfMul(c, d[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mkA(input int job, input int beat);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = {4'(job), 4'(beat)} ^ 8'(k);
    return r;
  endfunction

  function automatic logic [127:0] mkB(input int job, input int beat);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = {4'(beat), 4'(job)} ^ {4'(k), 4'h0};
    return r;
  endfunction

  // Codec model: CODEC_LAT register stages after the combinational GF product.
  logic [127:0] codecPipe [CODEC_LAT];
  always_ff @(posedge clk) begin
    codecPipe[0] <= gfVec(bus.oCoef1, bus.oCodecIn1) ^ gfVec(bus.oCoef2, bus.oCodecIn2);
    for (int i = 1; i < int'(CODEC_LAT); i++) codecPipe[i] <= codecPipe[i-1];
  end
  assign bus.iCodecOut = codecPipe[CODEC_LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int issued, pops, jobDones, readyViol, stableViol;
  int acceptCycle, firstIssueCycle, firstPopCycle, lastPopCycle, doneCycle;
  bit accepted, abEn, bSparse, prevHeld;
  logic [127:0] prevData;
  logic prevLast;
  logic [7:0] firstByte;
  logic [7:0] curC1, curC2;
  int curLen, curJob;
  logic [128:0] expQ [$];
  vecT tbl [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample everything mid-cycle, advance, then drive the next cycle's inputs.
  task automatic tick();
    logic aV, bV, aR, bR, oV, oR, oL, jd, jv, jr;
    logic [127:0] aD, bD, oD;
    logic [128:0] e;
    int sc;
    @(negedge clk);
    aV = bus.iAValid;   bV = bus.iBValid;   aR = bus.oAReady;   bR = bus.oBReady;
    aD = bus.iAData;    bD = bus.iBData;    oV = bus.oOutValid; oR = bus.iOutReady;
    oD = bus.oOutData;  oL = bus.oOutLast;  jd = bus.oJobDone;
    jv = bus.iJobValid; jr = bus.oJobReady;
    @(posedge clk);
    #1;
    sc = cyc;
    cyc++;
    if (jv && jr) begin
      accepted    = 1'b1;
      acceptCycle = sc;
    end
    if ((aR != bR) || (aR && !(aV && bV))) readyViol++;
    if (aR) begin
      expQ.push_back({1'(issued + 1 == curLen), gfVec(curC1, aD) ^ gfVec(curC2, bD)});
      if (issued == 0) firstIssueCycle = sc;
      issued++;
    end
    if (prevHeld && (!oV || oD !== prevData || oL !== prevLast)) stableViol++;
    prevHeld = oV && !oR;
    prevData = oD;
    prevLast = oL;
    if (oV && oR) begin
      pops++;
      if (pops == 1) begin
        firstPopCycle = sc;
        firstByte     = oD[7:0];
      end
      lastPopCycle = sc;
      if (expQ.size() == 0) begin
        check("spurious beat (queue size)", 128'(expQ.size()), 128'd1);
      end else begin
        e = expQ.pop_front();
        check("beat data", oD, e[127:0]);
        check("beat last", 128'(oL), 128'(e[128]));
      end
    end
    if (jd) begin
      jobDones++;
      doneCycle = sc;
    end
    bus.iAValid = abEn;
    bus.iBValid = abEn && (!bSparse || (cyc % 3 == 0));
    bus.iAData  = mkA(curJob, issued);
    bus.iBData  = mkB(curJob, issued);
  endtask

  task automatic submitJob(input int job, input logic [7:0] c1, input logic [7:0] c2,
                           input int len);
    curJob = job;  curC1 = c1;  curC2 = c2;  curLen = len;
    issued = 0;  pops = 0;  jobDones = 0;  accepted = 1'b0;
    firstPopCycle = -1;  doneCycle = -1;
    bus.iAData    = mkA(job, 0);
    bus.iBData    = mkB(job, 0);
    bus.iJobCoef1 = c1;
    bus.iJobCoef2 = c2;
    bus.iJobLen   = LEN_W'(len);
    bus.iJobValid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) tick();
    bus.iJobValid = 1'b0;
  endtask

  task automatic runJob(input vecT v, input int job);
    bSparse       = v.sparse;
    abEn          = 1'b1;
    bus.iOutReady = (v.stall == 0);
    submitJob(job, v.c1, v.c2, v.len);
    check("job accepted", 128'(accepted), 128'd1);
    if (!accepted) return;
    if (v.len == 0) begin
      check("empty job: ready again", 128'(bus.oJobReady), 128'd1);
      check("empty job: done pulse", 128'(bus.oJobDone), 128'd1);
    end
    if (v.stall > 0) begin
      repeat (v.stall) tick();
      check("beats issued under stall", 128'(issued), 128'(v.expStallIssued));
      bus.iOutReady = 1'b1;
    end
    for (int n = 0; n < 300 && !(jobDones > 0 && pops == v.len); n++) tick();
    repeat (4) tick();
    check("beats issued", 128'(issued), 128'(v.len));
    check("beats popped", 128'(pops), 128'(v.len));
    check("done pulses", 128'(jobDones), 128'd1);
    check("scoreboard empty", 128'(expQ.size()), 128'd0);
    if (v.len == 0) begin
      check("empty job done cycle", 128'(doneCycle), 128'(acceptCycle + 1));
    end else begin
      check("done after last pop", 128'(doneCycle), 128'(lastPopCycle + 1));
      check("first beat lane0", 128'(firstByte), 128'(v.expByte0));
    end
    if (v.chkLat) begin
      check("issue latency", 128'(firstIssueCycle - acceptCycle), 128'd1);
      check("result latency", 128'(firstPopCycle - firstIssueCycle), 128'(CODEC_LAT + 2));
    end
  endtask

  task automatic checkAllZero();
    check("rst oJobReady", 128'(bus.oJobReady), 128'd0);
    check("rst oAReady", 128'(bus.oAReady), 128'd0);
    check("rst oBReady", 128'(bus.oBReady), 128'd0);
    check("rst oBusy", 128'(bus.oBusy), 128'd0);
    check("rst oOutValid", 128'(bus.oOutValid), 128'd0);
    check("rst oOutData", bus.oOutData, 128'd0);
    check("rst oOutLast", 128'(bus.oOutLast), 128'd0);
    check("rst oJobDone", 128'(bus.oJobDone), 128'd0);
    check("rst oCoef", 128'({bus.oCoef1, bus.oCoef2}), 128'd0);
    check("rst oCodecIn1", bus.oCodecIn1, 128'd0);
    check("rst oCodecIn2", bus.oCodecIn2, 128'd0);
  endtask

  initial begin
    // Lane-0 expectations are hand-computed: job j sends A=0x(j)0, B=0x0(j) on beat 0.
    tbl[0] = '{8'h02, 8'h03, 4,  1'b0, 0,  1'b1, 0, 8'h23};
    tbl[1] = '{8'h11, 8'h22, 0,  1'b0, 0,  1'b0, 0, 8'h00};
    tbl[2] = '{8'h1D, 8'h80, 16, 1'b0, 30, 1'b0, 8, 8'hDD};
    tbl[3] = '{8'h57, 8'h83, 6,  1'b1, 0,  1'b0, 0, 8'h26};
    tbl[4] = '{8'h01, 8'h00, 3,  1'b0, 0,  1'b0, 0, 8'h50};
    tbl[5] = '{8'h00, 8'h01, 3,  1'b0, 0,  1'b0, 0, 8'h06};
    tbl[6] = '{8'h02, 8'h03, 12, 1'b0, 25, 1'b0, 8, 8'hE9};

    abEn = 1'b0;  bSparse = 1'b0;  prevHeld = 1'b0;  readyViol = 0;  stableViol = 0;
    issued = 0;  pops = 0;  jobDones = 0;  curLen = 0;  curJob = 0;  curC1 = '0;  curC2 = '0;
    bus.iJobValid = 1'b0;  bus.iJobCoef1 = '0;  bus.iJobCoef2 = '0;  bus.iJobLen = '0;
    bus.iAValid = 1'b0;  bus.iBValid = 1'b0;  bus.iAData = '0;  bus.iBData = '0;
    bus.iOutReady = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    checkAllZero();
    rst = 1'b0;
    tick();
    check("idle ready after reset", 128'(bus.oJobReady), 128'd1);

    for (int i = 0; i < 6; i++) runJob(tbl[i], i + 1);

    // Reset with three beats inside the codec pipeline.
    bSparse = 1'b0;
    abEn = 1'b1;
    bus.iOutReady = 1'b1;
    submitJob(15, 8'h02, 8'h03, 10);
    for (int n = 0; n < 20 && issued < 3; n++) tick();
    check("issued before reset", 128'(issued), 128'd3);
    abEn = 1'b0;
    bus.iAValid = 1'b0;
    bus.iBValid = 1'b0;
    bus.iOutReady = 1'b0;
    rst = 1'b1;
    tick();
    checkAllZero();
    rst = 1'b0;
    expQ.delete();
    prevHeld = 1'b0;
    jobDones = 0;
    pops = 0;
    bus.iOutReady = 1'b1;
    repeat (8) tick();
    check("no done after reset", 128'(jobDones), 128'd0);
    check("no beats after reset", 128'(pops), 128'd0);

    // Stalled job after reset: exactly OUT_DEPTH beats issue, so credits were restored.
    runJob(tbl[6], 7);

    check("A/B ready pairing", 128'(readyViol), 128'd0);
    check("output held under backpressure", 128'(stableViol), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
